// File: rtl/itr_ctrl_pkg.sv
// itr_ctrl_pkg: shared FSM encoding and vector address helper for the interrupt controller
package itr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;
  function automatic int unsigned vec_addr(input int unsigned ch, input int unsigned vbase, input int unsigned vstep);
    return vbase + ch * vstep;
  endfunction
endpackage

// File: rtl/itr_ctrl_if.sv
// itr_ctrl_if: request, mask, core handshake and status signals of the interrupt controller
interface itr_ctrl_if #(parameter int NCHAN = 4, parameter int MINSTW = 9, parameter int NESTD = 4);
  logic [NCHAN-1:0] irq;
  logic glb_en;
  logic mask_wr;
  logic [NCHAN-1:0] mask_in;
  logic ack;
  logic ret;
  logic itr;
  logic [MINSTW-1:0] itr_addr;
  logic [NCHAN-1:0] pend;
  logic [$clog2(NCHAN)-1:0] act_ch;
  logic [$clog2(NESTD+1)-1:0] depth;
  logic err;
  modport slave(input irq, glb_en, mask_wr, mask_in, ack, ret, output itr, itr_addr, pend, act_ch, depth, err);
  modport master(output irq, glb_en, mask_wr, mask_in, ack, ret, input itr, itr_addr, pend, act_ch, depth, err);
endinterface

// File: rtl/itr_prio_enc.sv
// itr_prio_enc: lowest-index-wins priority encoder
module itr_prio_enc #(parameter int N = 4, parameter int W = $clog2(N)) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [W-1:0] idx
);
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/itr_ctrl.sv
// itr_ctrl: vectored, prioritised, nesting interrupt controller
module itr_ctrl import itr_ctrl_pkg::*; #(
  parameter int NCHAN  = 4,
  parameter int MINSTW = 9,
  parameter int VBASE  = 1,
  parameter int VSTEP  = 2,
  parameter int NESTD  = 4
) (
  input logic clk,
  input logic rst,
  itr_ctrl_if.slave bus
);
  localparam int CHW = $clog2(NCHAN);
  localparam int DW  = $clog2(NESTD + 1);
  localparam int SW  = $clog2(NESTD);
  state_t state, state_nx;
  logic [NCHAN-1:0] irq_q, pend, mask, elig, clr;
  logic [CHW-1:0] req_ch, act_ch, sel;
  logic [CHW-1:0] stack [NESTD];
  logic [DW-1:0] depth;
  logic [MINSTW-1:0] itr_addr;
  logic itr, err, any, full, do_req, do_push, do_pop, do_wd, err_set;
  assign full = depth == DW'(NESTD);
  assign clr  = do_push ? (NCHAN'(1) << req_ch) : '0;
  // a channel may interrupt only when idle or when it outranks the channel in service
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCHAN; i++)
      elig[i] = pend[i] & mask[i] & bus.glb_en & (depth == '0 || CHW'(i) < act_ch);
  end
  itr_prio_enc #(.N(NCHAN), .W(CHW)) u_enc (.req(elig), .vld(any), .idx(sel));
  // next state and one-cycle action strobes
  always_comb begin
    state_nx = state;
    do_req   = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_wd    = 1'b0;
    case (state)
      IDLE: if (any && !full) begin
        do_req   = 1'b1;
        state_nx = REQ;
      end
      REQ: if (bus.ack) begin
        do_push  = 1'b1;
        state_nx = SERV;
      end else begin
        do_pop = bus.ret && depth != '0;
        if (!bus.glb_en || !mask[req_ch]) begin
          do_wd    = 1'b1;
          state_nx = (depth - DW'(do_pop)) == '0 ? IDLE : SERV;
        end
      end
      SERV: if (bus.ret) begin
        do_pop   = 1'b1;
        state_nx = depth == DW'(1) ? IDLE : SERV;
      end else if (any && !full) begin
        do_req   = 1'b1;
        state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
    err_set = (bus.ack && state != REQ) || (bus.ret && depth == '0) || (bus.ack && bus.ret && state == REQ);
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // edge detect, mask, request outputs and the active-channel stack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q    <= '0;
      pend     <= '0;
      mask     <= '0;
      itr      <= 1'b0;
      itr_addr <= '0;
      req_ch   <= '0;
      act_ch   <= '0;
      depth    <= '0;
      err      <= 1'b0;
      for (int i = 0; i < NESTD; i++) stack[i] <= '0;
    end else begin
      irq_q <= bus.irq;
      pend  <= (pend & ~clr) | (bus.irq & ~irq_q);
      if (bus.mask_wr) mask <= bus.mask_in;
      if (do_req) begin
        itr      <= 1'b1;
        itr_addr <= MINSTW'(vec_addr(32'(sel), VBASE, VSTEP));
        req_ch   <= sel;
      end
      if (do_push || do_wd) itr <= 1'b0;
      if (do_push) begin
        stack[SW'(depth)] <= req_ch;
        depth  <= depth + DW'(1);
        act_ch <= req_ch;
      end
      if (do_pop) begin
        depth  <= depth - DW'(1);
        act_ch <= depth > DW'(1) ? stack[SW'(depth - DW'(2))] : '0;
      end
      if (err_set) err <= 1'b1;
    end
  end
  assign bus.itr      = itr;
  assign bus.itr_addr = itr_addr;
  assign bus.pend     = pend;
  assign bus.act_ch   = act_ch;
  assign bus.depth    = depth;
  assign bus.err      = err;
endmodule
